// File: rtl/downcount_sched_if.sv
// Handshake bundle between client FSMs and the shared down-counter scheduler.
// The scheduler uses the slave modport; the client side uses master.
interface downcount_sched_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    // Valid/ready contract: req[i] is a level that the client holds high until
    // it sees done[i]; grant[i] marks ownership of the counter, done[i] is a
    // one-cycle completion pulse. Dropping req[i] while granted aborts service.
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] load_val;
    logic [NREQ-1:0]       grant;
    logic [WIDTH-1:0]      count;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic                  state_dbg;

    modport master (
        output req, load_val,
        input  grant, count, done, busy, state_dbg
    );

    modport slave (
        input  req, load_val,
        output grant, count, done, busy, state_dbg
    );
endinterface

// File: rtl/downcount_sched.sv
// Round-robin scheduler sharing one WIDTH-bit down counter among NREQ requesters.
// Define DOWNCOUNT_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration.
module downcount_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    downcount_sched_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t            state_q, state_n;
    logic [NREQ-1:0]   grant_q, grant_n;
    logic [NREQ-1:0]   done_q, done_n;
    logic [WIDTH-1:0]  count_q, count_n;
    logic [IW-1:0]     win_q, win_n;
    logic [IW-1:0]     sel;

`ifdef DOWNCOUNT_SCHED_FIXED_PRIO_EN
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r);
        logic [IW-1:0] w;
        logic          found;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[i]) begin
                w     = IW'(i);
                found = 1'b1;
            end
        end
        return w;
    endfunction
`else
    logic [IW-1:0]     last_q, last_n;

    // Search starts just past the last completed winner and wraps around.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] r,
                                           input logic [IW-1:0]   last);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && r[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction
`endif

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        count_n = count_q;
        done_n  = '0;
        win_n   = win_q;
`ifdef DOWNCOUNT_SCHED_FIXED_PRIO_EN
        sel     = pick(bus.req);
`else
        last_n  = last_q;
        sel     = pick(bus.req, last_q);
`endif
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win_n   = sel;
                    grant_n = NREQ'(1) << sel;
                    count_n = bus.load_val[int'(sel)*WIDTH +: WIDTH];
                    state_n = COUNT;
                end
            end
            COUNT: begin
                // Abort outranks completion so a withdrawn request never sees done.
                if (!bus.req[win_q]) begin
                    grant_n = '0;
                    count_n = '0;
                    state_n = IDLE;
                end else if (count_q == '0) begin
                    done_n[win_q] = 1'b1;
                    grant_n       = '0;
`ifndef DOWNCOUNT_SCHED_FIXED_PRIO_EN
                    last_n        = win_q;
`endif
                    state_n       = IDLE;
                end else begin
                    count_n = count_q - WIDTH'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            count_q <= '1;
            win_q   <= '0;
`ifndef DOWNCOUNT_SCHED_FIXED_PRIO_EN
            last_q  <= IW'(NREQ - 1);
`endif
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            done_q  <= done_n;
            count_q <= count_n;
            win_q   <= win_n;
`ifndef DOWNCOUNT_SCHED_FIXED_PRIO_EN
            last_q  <= last_n;
`endif
        end
    end

    assign bus.grant     = grant_q;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q == COUNT);
    assign bus.state_dbg = (state_q == COUNT);
endmodule
